wb_stage_lsu: RTL

- Parametrised successor to the pipeline's write-back stage. Selects the result source (ALU, load data or PC+4), extracts and extends load data by funct3 and address offset, and drives the register-file write port.
- Absorbs variable-latency memory responses with a two-state FSM. Asserts a stall request upstream while a load is outstanding.
- Maintains a retired-instruction counter (minstret source).
- Sits after MEM, drives the regfile write port and the forwarding unit.

---
 rtl/wb_stage_lsu.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wb_stage_lsu.sv
// Write-back stage with load formatting, variable-latency memory wait
// and retired-instruction counter.
module wb_stage_lsu #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64,
    parameter int RD_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_valid,
    input  logic [31:0]      i_instruction,
    input  logic             i_reg_write,
    input  logic [1:0]       i_wb_sel,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_pc_plus4,
    input  logic [XLEN-1:0]  i_mem_data,
    input  logic             i_mem_rvalid,
    input  logic [2:0]       i_addr_lsb,
    output logic [RD_W-1:0]  o_rd_index,
    output logic [XLEN-1:0]  o_rd_data,
    output logic             o_rd_we,
    output logic             o_wb_busy,
    output logic [CNT_W-1:0] o_retire_count
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    localparam bit WIDE = (XLEN == 64);

    state_e            state_q, state_d;
    logic [RD_W-1:0]   rd_idx_q, rd_idx_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              rd_we_q, rd_we_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RD_W-1:0]   cap_rd_q, cap_rd_d;
    logic [2:0]        cap_f3_q, cap_f3_d;
    logic [2:0]        cap_lsb_q, cap_lsb_d;
    logic              cap_rw_q, cap_rw_d;

    logic [RD_W-1:0]   in_rd;
    logic [2:0]        in_f3;
    logic              accept;
    logic              is_load;
    logic [XLEN-1:0]   wb_value;
    logic              unused_instr;

    assign in_rd   = RD_W'(i_instruction[11:7]);
    assign in_f3   = i_instruction[14:12];
    assign accept  = i_valid && !i_stall;
    assign is_load = (i_wb_sel == 2'b01);

    assign unused_instr = ^{i_instruction[31:15], i_instruction[6:0]};

    // Narrow builds fold LD/LWU/reserved onto LW and ignore lsb[2].
    function automatic logic [XLEN-1:0] load_fmt(
        input logic [XLEN-1:0] word,
        input logic [2:0]      f3,
        input logic [2:0]      lsb
    );
        logic [63:0] s;
        logic [63:0] r;
        logic [5:0]  sh;
        sh = WIDE ? {lsb, 3'b000} : {1'b0, lsb[1:0], 3'b000};
        s  = 64'(word) >> sh;
        unique case (f3)
            3'b000: r = {{56{s[7]}}, s[7:0]};
            3'b001: r = {{48{s[15]}}, s[15:0]};
            3'b010: r = {{32{s[31]}}, s[31:0]};
            3'b100: r = {56'd0, s[7:0]};
            3'b101: r = {48'd0, s[15:0]};
            3'b110: r = WIDE ? {32'd0, s[31:0]}
                             : {{32{s[31]}}, s[31:0]};
            3'b011,
            3'b111: r = WIDE ? s : {{32{s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r[XLEN-1:0];
    endfunction

    always_comb begin
        wb_value = i_alu_result;
        unique case (i_wb_sel)
            2'b01:   wb_value = load_fmt(i_mem_data, in_f3, i_addr_lsb);
            2'b10:   wb_value = i_pc_plus4;
            default: wb_value = i_alu_result;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_idx_d  = rd_idx_q;
        rd_data_d = rd_data_q;
        rd_we_d   = 1'b0;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        cap_rd_d  = cap_rd_q;
        cap_f3_d  = cap_f3_q;
        cap_lsb_d = cap_lsb_q;
        cap_rw_d  = cap_rw_q;
        unique case (state_q)
            IDLE: begin
                if (accept && is_load && !i_mem_rvalid) begin
                    cap_rd_d  = in_rd;
                    cap_f3_d  = in_f3;
                    cap_lsb_d = i_addr_lsb;
                    cap_rw_d  = i_reg_write;
                    busy_d    = 1'b1;
                    state_d   = WAIT_MEM;
                end else if (accept) begin
                    rd_idx_d  = in_rd;
                    rd_data_d = wb_value;
                    rd_we_d   = i_reg_write && (in_rd != '0);
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            WAIT_MEM: begin
                // Response completes regardless of stall so it is never lost.
                if (i_mem_rvalid) begin
                    rd_idx_d  = cap_rd_q;
                    rd_data_d = load_fmt(i_mem_data, cap_f3_q, cap_lsb_q);
                    rd_we_d   = cap_rw_q && (cap_rd_q != '0);
                    cnt_d     = cnt_q + CNT_W'(1);
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
            rd_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            cap_rd_q  <= '0;
            cap_f3_q  <= '0;
            cap_lsb_q <= '0;
            cap_rw_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_idx_q  <= rd_idx_d;
            rd_data_q <= rd_data_d;
            rd_we_q   <= rd_we_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            cap_rd_q  <= cap_rd_d;
            cap_f3_q  <= cap_f3_d;
            cap_lsb_q <= cap_lsb_d;
            cap_rw_q  <= cap_rw_d;
        end
    end

    assign o_rd_index     = rd_idx_q;
    assign o_rd_data      = rd_data_q;
    assign o_rd_we        = rd_we_q;
    assign o_wb_busy      = busy_q;
    assign o_retire_count = cnt_q;

endmodule
